// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bus of the shared-UART arbiter.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            err;
  logic [ID_W-1:0]               grant_id;
  logic                          arb_busy;
  logic [DATA_WIDTH-1:0]         uart_data;
  logic                          uart_data_en;
  logic                          uart_tx_busy;

  modport master (
    input  req, req_data, uart_tx_busy,
    output ack, err, grant_id, arb_busy, uart_data, uart_data_en
  );

  modport slave (
    output req, req_data, uart_tx_busy,
    input  ack, err, grant_id, arb_busy, uart_data, uart_data_en
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to abort launches whose busy never rises (err pulse).
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               rstn,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         grant_id_q, grant_id_d;
  logic [ID_W-1:0]         last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0]   uart_data_q, uart_data_d;
  logic                    uart_data_en_q, uart_data_en_d;
  logic                    arb_busy_q, arb_busy_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [NUM_REQ-1:0]      err_q, err_d;

  logic [NUM_REQ-1:0]      eligible_c;
  logic                    win_valid_c;
  logic [ID_W-1:0]         win_id_c;
  logic [DATA_WIDTH-1:0]   win_data_c;

  // First eligible index at or after last+1, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                            input logic [ID_W-1:0]    last);
    logic            found;
    logic [ID_W-1:0] id;
    int unsigned     idx;
    found = 1'b0;
    id    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(last) + k + 32'd1;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[ID_W'(idx)]) begin
        found = 1'b1;
        id    = ID_W'(idx);
      end
    end
    return {found, id};
  endfunction

  // A requester in its ack/err cycle must not be re-granted immediately.
  assign eligible_c = bus.req & ~ack_q & ~err_q;
  assign {win_valid_c, win_id_c} = rr_pick(eligible_c, last_grant_q);

  always_comb begin
    win_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_id_c == ID_W'(i)) win_data_c = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_c;

  // Cycles spent in WAIT_BUSY; zero everywhere else.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT_BUSY && !bus.uart_tx_busy) cnt_d = cnt_q + CNT_W'(1);
  end

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    uart_data_d    = uart_data_q;
    uart_data_en_d = 1'b0;
    ack_d          = '0;
    err_d          = '0;

    case (state_q)
      IDLE: begin
        if (!bus.uart_tx_busy && win_valid_c) begin
          grant_id_d     = win_id_c;
          uart_data_d    = win_data_c;
          uart_data_en_d = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.uart_tx_busy) begin
          state_d = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (timeout_c) begin
          state_d      = IDLE;
          err_d        = NUM_REQ'(1) << grant_id_q;
          last_grant_d = grant_id_q;
        end
`endif
      end
      WAIT_DONE: begin
        if (!bus.uart_tx_busy) begin
          state_d      = IDLE;
          ack_d        = NUM_REQ'(1) << grant_id_q;
          last_grant_d = grant_id_q;
        end
      end
      default: state_d = IDLE;
    endcase

    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      last_grant_q   <= ID_W'(NUM_REQ - 1);
      uart_data_q    <= '0;
      uart_data_en_q <= 1'b0;
      arb_busy_q     <= 1'b0;
      ack_q          <= '0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      uart_data_q    <= uart_data_d;
      uart_data_en_q <= uart_data_en_d;
      arb_busy_q     <= arb_busy_d;
      ack_q          <= ack_d;
      err_q          <= err_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.err          = err_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.arb_busy     = arb_busy_q;
  assign bus.uart_data    = uart_data_q;
  assign bus.uart_data_en = uart_data_en_q;
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing one UART transmitter (range 2..8).
REQ-002 Parameter DATA_WIDTH, default 8: byte width per transfer; matches transmitter data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: cycles allowed for tx busy to rise after a launch (used only with UART_ARB_TIMEOUT_EN).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rstn  input  1  synchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester transfer request, level, held until ack or err.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 ack  output  NUM_REQ  one-cycle pulse: requester's byte fully shifted out.
REQ-009 err  output  NUM_REQ  one-cycle pulse: requester's transfer aborted by timeout.
REQ-010 grant_id  output  clog2(NUM_REQ)  index of current or last granted requester.
REQ-011 arb_busy  output  1  high in every state except IDLE.
REQ-012 uart_data  output  DATA_WIDTH  byte to transmitter data input.
REQ-013 uart_data_en  output  1  one-cycle launch strobe to transmitter enable.
REQ-014 uart_tx_busy  input  1  transmitter busy flag.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, all transitions on the rising clk edge.
REQ-016 IDLE: if uart_tx_busy=0 and any eligible req=1, the arbiter SHALL latch the winner index and its req_data, then go to ISSUE; if uart_tx_busy=1, it SHALL not arbitrate.
REQ-017 A request is eligible when req[i]=1 and ack[i]=0 and err[i]=0 in the same cycle, so a requester is not re-granted in its completion cycle.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; the lowest index at or after that point wins, with wrap-around.
REQ-019 ISSUE: uart_data_en=1 for exactly this one cycle, uart_data = latched byte; next state WAIT_BUSY.
REQ-020 uart_data SHALL hold the latched byte from ISSUE until the return to IDLE; changes to req_data after the grant SHALL be ignored.
REQ-021 WAIT_BUSY: on uart_tx_busy=1 -> WAIT_DONE.
REQ-022 WAIT_DONE: on uart_tx_busy=0 -> IDLE, ack[grant_id]=1 for the following single cycle, last_grant <= grant_id.
REQ-023 Latency: req rising in IDLE at cycle N (transmitter idle) -> uart_data_en high at cycle N+1.
REQ-024 Requester deasserting req after grant SHALL NOT cancel the transfer; ack is still pulsed.
REQ-025 At most one ack or err bit SHALL be high in any cycle; ack and err SHALL never be high together.
REQ-026 Simultaneous requests: exactly one grant per transfer; the others remain pending without loss.

Reset
REQ-027 rstn=0 sampled at a clk edge SHALL force state IDLE, ack=0, err=0, uart_data_en=0, uart_data=0, grant_id=0, arb_busy=0, and the timeout counter to 0.
REQ-028 After reset, last_grant = NUM_REQ-1, so requester 0 has first priority.
REQ-029 Reset mid-transfer SHALL abandon the transfer silently, with no ack or err pulse; the requester's req is re-arbitrated after reset.

Configuration
REQ-030 Macro UART_ARB_TIMEOUT_EN defined: in WAIT_BUSY a counter SHALL count cycles from entry; when it reaches TIMEOUT_CYCLES with uart_tx_busy still 0, the FSM SHALL go to IDLE, pulse err[grant_id] for one cycle, and set last_grant <= grant_id.
REQ-031 Macro UART_ARB_TIMEOUT_EN undefined: WAIT_BUSY SHALL wait indefinitely, err SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-032 Single request: req=2'b01, req_data[7:0]=8'hA5; transmitter model busy 3 cycles after launch for 10 cycles -> uart_data_en one pulse with uart_data=8'hA5 at N+1, then ack=2'b01 one cycle after busy falls.
REQ-033 Contention: req=2'b11 held, bytes 8'h11/8'h22, from reset -> order 8'h11, 8'h22, 8'h11, 8'h22, with acks alternating 01, 10.
REQ-034 Ack-cycle exclusion: req0 held high through its ack with req1=0 -> no second uart_data_en in the ack cycle; the next launch occurs one cycle later.
REQ-035 Busy gating: uart_tx_busy held 1 externally while req=2'b01 -> no uart_data_en until busy drops; launch follows within 1 cycle.
REQ-036 Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): launch with busy never rising -> err=2'b01 pulse 16 cycles after WAIT_BUSY entry, ack stays 0, state returns to IDLE.
REQ-037 Reset mid-transfer: rstn=0 for 1 cycle while in WAIT_DONE -> all outputs 0, no ack; a held req is re-granted with requester 0 first.
